// File: rtl/ga_sched_pkg.sv
// Shared types and constants for the GA population evaluation scheduler.
package ga_sched_pkg;

  localparam int FITNESS_WIDTH       = 35;
  localparam int CHROM_WIDTH_DEFAULT = 992;
  localparam int NUM_ERROR_SUMS      = 8;

  typedef logic [NUM_ERROR_SUMS-1:0][31:0] error_sum_t;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StFetch = 4'd1,
    StStart = 4'd2,
    StRun   = 4'd3,
    StAck   = 4'd4,
    StWrite = 4'd5,
    StNext  = 4'd6,
    StDone  = 4'd7
  } state_t;

endpackage

// File: rtl/fitness_reducer.sv
// Combinational adder tree reducing eight 32-bit error sums to a 35-bit fitness.
module fitness_reducer
  import ga_sched_pkg::*;
(
  input  error_sum_t                 iErrorSums,
  output logic [FITNESS_WIDTH-1:0]   oFitness
);

  logic [3:0][32:0] level1;
  logic [1:0][33:0] level2;

  // Each level widens by one bit, so the final 35-bit sum cannot overflow.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level1[i] = {1'b0, iErrorSums[2*i]} + {1'b0, iErrorSums[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      level2[i] = {1'b0, level1[2*i]} + {1'b0, level1[2*i+1]};
    end
    oFitness = {1'b0, level2[0]} + {1'b0, level2[1]};
  end

endmodule

// File: rtl/population_evaluation_scheduler.sv
// Walks one generation: fetch each chromosome, run the processor, write back
// its fitness and track the lowest-error individual.
module population_evaluation_scheduler
  import ga_sched_pkg::*;
#(
  parameter int MAX_POPULATION = 64,
  parameter int CHROM_WIDTH    = CHROM_WIDTH_DEFAULT
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iStartGeneration,
  input  logic [7:0]                iPopulationSize,
  output logic                      oChromRequest,
  output logic [7:0]                oChromIndex,
  input  logic                      iChromValid,
  input  logic [CHROM_WIDTH-1:0]    iChromData,
  output logic [CHROM_WIDTH-1:0]    oConcatedChromDescription,
  output logic                      oStartProcessing,
  input  logic                      iReadyToProcess,
  input  logic                      iDoneProcessing,
  output logic                      oDoneProcessingFeedback,
  input  error_sum_t                iErrorSums,
  output logic                      oFitnessWrite,
  output logic [7:0]                oFitnessIndex,
  output logic [FITNESS_WIDTH-1:0]  oFitness,
  output logic [7:0]                oBestIndex,
  output logic [FITNESS_WIDTH-1:0]  oBestFitness,
  output logic                      oGenerationDone,
  output logic                      oBusy,
  output logic [3:0]                oState
);

  localparam logic [7:0] MaxPop = 8'(MAX_POPULATION);

  state_t                    state, stateNext;
  logic [7:0]                size, index, clampedSize, lastIndex;
  logic [CHROM_WIDTH-1:0]    description;
  logic [FITNESS_WIDTH-1:0]  fitness, fitnessSum, bestFitness;
  logic [7:0]                bestIndex;
  logic                      generationDone;

  assign clampedSize = (iPopulationSize > MaxPop) ? MaxPop : iPopulationSize;
  assign lastIndex   = size - 8'd1;

  fitness_reducer uReducer (
    .iErrorSums (iErrorSums),
    .oFitness   (fitnessSum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= StIdle;
    else        state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    stateNext               = state;
    oChromRequest           = 1'b0;
    oStartProcessing        = 1'b0;
    oDoneProcessingFeedback = 1'b0;
    oFitnessWrite           = 1'b0;
    case (state)
      StIdle:  if (iStartGeneration) stateNext = (clampedSize == 8'd0) ? StDone : StFetch;
      StFetch: begin
        oChromRequest = 1'b1;
        if (iChromValid) stateNext = StStart;
      end
      // A processor left in DONE by an earlier abort is flushed before starting.
      StStart: begin
        if (iDoneProcessing) begin
          oDoneProcessingFeedback = 1'b1;
        end else if (iReadyToProcess) begin
          oStartProcessing = 1'b1;
          stateNext        = StRun;
        end
      end
      StRun:   if (iDoneProcessing) stateNext = StAck;
      StAck: begin
        oDoneProcessingFeedback = 1'b1;
        stateNext               = StWrite;
      end
      StWrite: begin
        oFitnessWrite = 1'b1;
        stateNext     = StNext;
      end
      StNext:  stateNext = (index == lastIndex) ? StDone : StFetch;
      StDone:  if (!iStartGeneration) stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      size           <= '0;
      index          <= '0;
      description    <= '0;
      fitness        <= '0;
      bestFitness    <= '1;
      bestIndex      <= '0;
      generationDone <= 1'b0;
    end else begin
      case (state)
        StIdle: if (iStartGeneration) begin
          size           <= clampedSize;
          index          <= '0;
          bestFitness    <= '1;
          bestIndex      <= '0;
          generationDone <= (clampedSize == 8'd0);
        end
        StFetch: if (iChromValid) description <= iChromData;
        StRun:   if (iDoneProcessing) fitness <= fitnessSum;
        // Strict compare: on a tie the earlier (lower) index is kept.
        StWrite: if (fitness < bestFitness) begin
          bestFitness <= fitness;
          bestIndex   <= index;
        end
        StNext: begin
          if (index == lastIndex) generationDone <= 1'b1;
          else                    index          <= index + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign oChromIndex               = index;
  assign oConcatedChromDescription = description;
  assign oFitnessIndex             = index;
  assign oFitness                  = fitness;
  assign oBestIndex                = bestIndex;
  assign oBestFitness              = bestFitness;
  assign oGenerationDone           = generationDone;
  assign oBusy                     = (state != StIdle);
  assign oState                    = state;

endmodule

// File: tb/tb_population_evaluation_scheduler.sv
// Drives whole generations against behavioural store/processor models and
// compares write-backs and best tracking with a reference computed here.
module tb_population_evaluation_scheduler;
  import ga_sched_pkg::*;

  localparam int CW = CHROM_WIDTH_DEFAULT;
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2, P_STALE = 3;

  logic              iClock = 1'b0;
  logic              iReset;
  logic              iStartGeneration;
  logic [7:0]        iPopulationSize;
  logic              oChromRequest;
  logic [7:0]        oChromIndex;
  logic              iChromValid;
  logic [CW-1:0]     iChromData;
  logic [CW-1:0]     oConcatedChromDescription;
  logic              oStartProcessing;
  logic              iReadyToProcess;
  logic              iDoneProcessing;
  logic              oDoneProcessingFeedback;
  error_sum_t        iErrorSums;
  logic              oFitnessWrite;
  logic [7:0]        oFitnessIndex;
  logic [34:0]       oFitness;
  logic [7:0]        oBestIndex;
  logic [34:0]       oBestFitness;
  logic              oGenerationDone;
  logic              oBusy;
  logic [3:0]        oState;

  population_evaluation_scheduler #(.MAX_POPULATION(64), .CHROM_WIDTH(CW)) dut (
    .iClock(iClock), .iReset(iReset), .iStartGeneration(iStartGeneration),
    .iPopulationSize(iPopulationSize), .oChromRequest(oChromRequest),
    .oChromIndex(oChromIndex), .iChromValid(iChromValid), .iChromData(iChromData),
    .oConcatedChromDescription(oConcatedChromDescription),
    .oStartProcessing(oStartProcessing), .iReadyToProcess(iReadyToProcess),
    .iDoneProcessing(iDoneProcessing), .oDoneProcessingFeedback(oDoneProcessingFeedback),
    .iErrorSums(iErrorSums), .oFitnessWrite(oFitnessWrite), .oFitnessIndex(oFitnessIndex),
    .oFitness(oFitness), .oBestIndex(oBestIndex), .oBestFitness(oBestFitness),
    .oGenerationDone(oGenerationDone), .oBusy(oBusy), .oState(oState)
  );

  always #5 iClock = ~iClock;

  typedef struct { int idx; logic [34:0] fit; } wr_t;

  int passCount = 0;
  int checkCount = 0;

  // Stimulus plan per individual
  logic [31:0]   planSums [64][8];
  int            latency  [64];
  int            runLen   [64];
  logic [CW-1:0] descs    [64];

  // Processor model state (persists across generations, like a real processor)
  int procMode = P_IDLE;
  int procCnt  = 0;
  int procIdx  = 0;
  bit procFirst = 0;

  // Observations from the last generation
  wr_t writes[$];
  int  startSeen, fbCnt, doneCycle;
  bit  bothSeen, reqSeen, descBad, timedOut, aborted;

  function automatic logic [CW-1:0] rand_wide();
    logic [CW-1:0] v;
    v = '0;
    for (int w = 0; w < CW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [34:0] ref_fitness(int i);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'(planSums[i][k]);
    return 35'(s);
  endfunction

  function automatic int ref_best_index(int n);
    int b = 0;
    for (int i = 1; i < n; i++) if (ref_fitness(i) < ref_fitness(b)) b = i;
    return b;
  endfunction

  function automatic logic [68:0] snap_outputs();
    return {oChromRequest, oChromIndex, oStartProcessing, oDoneProcessingFeedback,
            oFitnessWrite, oFitnessIndex, oFitness, oBestIndex, oGenerationDone,
            oBusy, oState};
  endfunction

  // Runs one generation cycle by cycle; inputs change at the falling edge and
  // outputs are sampled 1ns later, i.e. as the next rising edge will see them.
  task automatic run_gen(input int size, input int abortIdx);
    int fetchCnt = 0;
    writes.delete();
    startSeen = 0; fbCnt = 0; doneCycle = -1;
    bothSeen = 0; reqSeen = 0; descBad = 0; timedOut = 1; aborted = 0;
    for (int i = 0; i < 64; i++) descs[i] = rand_wide();
    @(negedge iClock);
    iStartGeneration = 1'b1;
    iPopulationSize  = 8'(size);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc > 0) @(negedge iClock);
      if (abortIdx >= 0 && procMode == P_BUSY && procIdx == abortIdx) begin
        #2 iReset = 1'b1;
        iStartGeneration = 1'b0;
        aborted = 1; timedOut = 0;
        return;
      end
      if (oBusy) iStartGeneration = 1'b0;
      // Population store
      iChromValid = 1'b0;
      iChromData  = rand_wide();
      if (oChromRequest) begin
        if (fetchCnt == latency[int'(oChromIndex)]) begin
          iChromValid = 1'b1;
          iChromData  = descs[int'(oChromIndex)];
        end
        fetchCnt++;
      end else begin
        fetchCnt = 0;
      end
      // Processor
      iReadyToProcess = (procMode == P_IDLE);
      iDoneProcessing = (procMode == P_DONE || procMode == P_STALE);
      for (int k = 0; k < 8; k++)
        iErrorSums[k] = (procMode == P_DONE && procFirst) ? planSums[procIdx][k] : $urandom;
      #1;
      if (oStartProcessing && oDoneProcessingFeedback) bothSeen = 1;
      if (oChromRequest) reqSeen = 1;
      if (oStartProcessing) startSeen++;
      if (oDoneProcessingFeedback) fbCnt++;
      if (oFitnessWrite) writes.push_back('{int'(oFitnessIndex), oFitness});
      if (procMode == P_BUSY && oBusy && int'(oChromIndex) == procIdx &&
          oConcatedChromDescription !== descs[procIdx]) descBad = 1;
      case (procMode)
        P_IDLE: if (oStartProcessing) begin
          procMode = P_BUSY; procIdx = int'(oChromIndex); procCnt = runLen[procIdx];
        end
        P_BUSY: if (procCnt <= 1) begin procMode = P_DONE; procFirst = 1; end
                else procCnt--;
        P_DONE: begin procFirst = 0; if (oDoneProcessingFeedback) procMode = P_IDLE; end
        default: if (oDoneProcessingFeedback) begin
          procCnt--;
          if (procCnt <= 0) procMode = P_IDLE;
        end
      endcase
      if (cyc > 0 && oGenerationDone) begin
        doneCycle = cyc; timedOut = 0;
        break;
      end
    end
  endtask

  task automatic plan_simple(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) planSums[i][k] = 32'd0;
      latency[i] = 1; runLen[i] = 3;
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1; iStartGeneration = 1'b0; iPopulationSize = '0;
    iChromValid = 1'b0; iChromData = '0; iReadyToProcess = 1'b0;
    iDoneProcessing = 1'b0; iErrorSums = '0;
    #1;
    checkCount++; if (snap_outputs() !== '0) $display("FAIL reset_outputs: got %h expected 0", snap_outputs()); else passCount++;
    checkCount++; if (oBestFitness !== '1) $display("FAIL reset_best_fitness: got %h expected all-ones", oBestFitness); else passCount++;
    checkCount++; if (oConcatedChromDescription !== '0) $display("FAIL reset_description: got nonzero expected 0"); else passCount++;
    @(negedge iClock); @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock); #1;
    checkCount++; if (oState !== 4'd0) $display("FAIL reset_state_after_release: got %0d expected 0", oState); else passCount++;
  endtask

  task automatic test_basic();
    logic [34:0] expFit [3] = '{35'd1, 35'd0, 35'd4};
    plan_simple(3);
    planSums[0][0] = 32'd1;
    planSums[2][0] = 32'd2; planSums[2][1] = 32'd2;
    run_gen(3, -1);
    checkCount++; if (timedOut) $display("FAIL basic_timeout: got timeout expected done"); else passCount++;
    checkCount++; if (writes.size() != 3) $display("FAIL basic_write_count: got %0d expected 3", writes.size()); else passCount++;
    for (int i = 0; i < 3 && i < writes.size(); i++) begin
      checkCount++; if (writes[i].idx != i) $display("FAIL basic_write_index[%0d]: got %0d expected %0d", i, writes[i].idx, i); else passCount++;
      checkCount++; if (writes[i].fit !== expFit[i]) $display("FAIL basic_write_fitness[%0d]: got %0h expected %0h", i, writes[i].fit, expFit[i]); else passCount++;
    end
    checkCount++; if (oBestIndex !== 8'd1) $display("FAIL basic_best_index: got %0d expected 1", oBestIndex); else passCount++;
    checkCount++; if (oBestFitness !== 35'd0) $display("FAIL basic_best_fitness: got %0h expected 0", oBestFitness); else passCount++;
    checkCount++; if (oGenerationDone !== 1'b1) $display("FAIL basic_generation_done: got %b expected 1", oGenerationDone); else passCount++;
    checkCount++; if (startSeen != 3 || fbCnt != 3) $display("FAIL basic_handshake_counts: got start=%0d ack=%0d expected 3/3", startSeen, fbCnt); else passCount++;
    checkCount++; if (bothSeen) $display("FAIL basic_start_ack_overlap: got overlap expected none"); else passCount++;
    checkCount++; if (descBad) $display("FAIL basic_description_stable: got change expected stable"); else passCount++;
  endtask

  task automatic test_zero_size();
    run_gen(0, -1);
    checkCount++; if (doneCycle < 1 || doneCycle > 2) $display("FAIL zero_done_latency: got %0d expected 1..2", doneCycle); else passCount++;
    checkCount++; if (reqSeen || startSeen != 0) $display("FAIL zero_no_activity: got req=%0b start=%0d expected 0/0", reqSeen, startSeen); else passCount++;
    checkCount++; if (oBestFitness !== '1) $display("FAIL zero_best_fitness: got %h expected all-ones", oBestFitness); else passCount++;
    checkCount++; if (writes.size() != 0) $display("FAIL zero_writes: got %0d expected 0", writes.size()); else passCount++;
  endtask

  task automatic test_ties();
    plan_simple(3);
    planSums[0][0] = 32'd5;
    planSums[1][0] = 32'd3; planSums[1][1] = 32'd4;
    for (int k = 0; k < 5; k++) planSums[2][k] = 32'd1;
    run_gen(3, -1);
    checkCount++; if (oBestIndex !== 8'd0) $display("FAIL tie_best_index: got %0d expected 0", oBestIndex); else passCount++;
    checkCount++; if (oBestFitness !== 35'd5) $display("FAIL tie_best_fitness: got %0h expected 5", oBestFitness); else passCount++;
  endtask

  task automatic test_stale_done();
    plan_simple(1);
    planSums[0][3] = 32'd9;
    procMode = P_STALE; procCnt = 4;
    run_gen(1, -1);
    checkCount++; if (fbCnt != 5) $display("FAIL stale_ack_count: got %0d expected 5", fbCnt); else passCount++;
    checkCount++; if (startSeen != 1) $display("FAIL stale_start_count: got %0d expected 1", startSeen); else passCount++;
    checkCount++; if (bothSeen) $display("FAIL stale_overlap: got overlap expected none"); else passCount++;
    checkCount++; if (writes.size() != 1 || writes[0].fit !== 35'd9) $display("FAIL stale_fitness: got n=%0d expected one write of 9", writes.size()); else passCount++;
  endtask

  task automatic test_reset_mid_run();
    plan_simple(3);
    planSums[0][1] = 32'd7; planSums[1][2] = 32'd3; planSums[2][7] = 32'd11;
    runLen[1] = 6;
    run_gen(3, 1);
    checkCount++; if (!aborted) $display("FAIL abort_reached: got no RUN at index 1 expected abort"); else passCount++;
    #1;
    checkCount++; if (snap_outputs() !== '0) $display("FAIL abort_async_outputs: got %h expected 0", snap_outputs()); else passCount++;
    checkCount++; if (oBestFitness !== '1 || oConcatedChromDescription !== '0) $display("FAIL abort_async_regs: got best=%h expected all-ones and zero description", oBestFitness); else passCount++;
    @(negedge iClock);
    iReset = 1'b0;
    run_gen(3, -1);
    checkCount++; if (writes.size() != 3 || writes[0].idx != 0) $display("FAIL restart_from_zero: got n=%0d expected 3 writes starting at 0", writes.size()); else passCount++;
    for (int i = 0; i < writes.size(); i++) begin
      checkCount++; if (writes[i].fit !== ref_fitness(i)) $display("FAIL restart_fitness[%0d]: got %0h expected %0h", i, writes[i].fit, ref_fitness(i)); else passCount++;
    end
    checkCount++; if (startSeen != 3) $display("FAIL restart_start_count: got %0d expected 3", startSeen); else passCount++;
    checkCount++; if (oBestIndex !== 8'd1 || oBestFitness !== 35'd3) $display("FAIL restart_best: got %0d/%0h expected 1/3", oBestIndex, oBestFitness); else passCount++;
  endtask

  task automatic test_latency_extremes();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) planSums[i][k] = 32'hFFFF_FFFF;
      latency[i] = (i % 2 == 0) ? 0 : 7;
      runLen[i]  = 2 + i;
    end
    run_gen(4, -1);
    checkCount++; if (writes.size() != 4) $display("FAIL max_write_count: got %0d expected 4", writes.size()); else passCount++;
    for (int i = 0; i < writes.size(); i++) begin
      checkCount++; if (writes[i].fit !== 35'h7_FFFF_FFF8) $display("FAIL max_fitness[%0d]: got %0h expected 7fffffff8", i, writes[i].fit); else passCount++;
    end
    checkCount++; if (oBestIndex !== 8'd0 || oBestFitness !== 35'h7_FFFF_FFF8) $display("FAIL max_best: got %0d/%0h expected 0/7fffffff8", oBestIndex, oBestFitness); else passCount++;
    checkCount++; if (descBad) $display("FAIL max_description_stable: got change expected stable"); else passCount++;
  endtask

  task automatic test_random();
    for (int g = 0; g < 5; g++) begin
      int size = (g == 4) ? 255 : $urandom_range(1, 12);
      int n    = (size > 64) ? 64 : size;
      for (int i = 0; i < 64; i++) begin
        for (int k = 0; k < 8; k++)
          planSums[i][k] = (g % 2 == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        latency[i] = $urandom_range(0, 5);
        runLen[i]  = $urandom_range(1, 4);
      end
      run_gen(size, -1);
      checkCount++; if (timedOut || writes.size() != n) $display("FAIL rand%0d_write_count: got %0d expected %0d", g, writes.size(), n); else passCount++;
      for (int i = 0; i < writes.size() && i < n; i++) begin
        checkCount++;
        if (writes[i].idx != i || writes[i].fit !== ref_fitness(i))
          $display("FAIL rand%0d_write[%0d]: got %0d/%0h expected %0d/%0h", g, i, writes[i].idx, writes[i].fit, i, ref_fitness(i));
        else passCount++;
      end
      checkCount++;
      if (oBestIndex !== 8'(ref_best_index(n)) || oBestFitness !== ref_fitness(ref_best_index(n)))
        $display("FAIL rand%0d_best: got %0d/%0h expected %0d/%0h", g, oBestIndex, oBestFitness, ref_best_index(n), ref_fitness(ref_best_index(n)));
      else passCount++;
      checkCount++; if (startSeen != n || fbCnt != n || bothSeen || descBad) $display("FAIL rand%0d_handshake: got start=%0d ack=%0d overlap=%0b desc=%0b expected %0d/%0d/0/0", g, startSeen, fbCnt, bothSeen, descBad, n, n); else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_ties();
    test_stale_done();
    test_reset_mid_run();
    test_latency_extremes();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/population_evaluation_scheduler.md
# population_evaluation_scheduler

Sequences one generation of fitness evaluation through the chromosome processing state machine. Fetches each chromosome description from the population store, presents it to the processor, and starts a run. Collects the eight per-bit error sums, reduces them to a scalar fitness, and writes the fitness back. Tracks the best (lowest-error) individual and raises a generation-done flag for the GA host logic.

## Interface
Parameters:
- MAX_POPULATION, 64, upper bound on individuals per generation; `iPopulationSize` is clamped to it.
- CHROM_WIDTH, 992, chromosome description width.

Ports:
- iClock  in  1  system clock; all logic on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStartGeneration  in  1  level; sampled in IDLE only.
- iPopulationSize  in  8  number of individuals; latched at start.
- oChromRequest  out  1  fetch request to the population store.
- oChromIndex  out  8  index being fetched or evaluated.
- iChromValid  in  1  population store data valid.
- iChromData  in  CHROM_WIDTH  chromosome description.
- oConcatedChromDescription  out  CHROM_WIDTH  registered description to the processor.
- oStartProcessing  out  1  start pulse to the processor.
- iReadyToProcess  in  1  processor is in IDLE.
- iDoneProcessing  in  1  processor is in DONE.
- oDoneProcessingFeedback  out  1  acknowledge to the processor.
- iErrorSums  in  8x32  per-output-bit error counts.
- oFitnessWrite  out  1  one-cycle fitness write strobe.
- oFitnessIndex  out  8  index for the fitness write.
- oFitness  out  35  sum of the eight error sums.
- oBestIndex  out  8  index of the lowest fitness so far.
- oBestFitness  out  35  lowest fitness so far.
- oGenerationDone  out  1  level; held until the next start.
- oBusy  out  1  high whenever state is not IDLE.
- oState  out  4  state code, for debug.

## Operation
- States: IDLE, FETCH, START, RUN, ACK, WRITE, NEXT, DONE.
- IDLE:
  - On iStartGeneration, latch size = min(iPopulationSize, MAX_POPULATION).
  - Set index=0, oBestFitness=all-ones, oBestIndex=0, clear oGenerationDone.
  - If size==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - Hold oChromRequest=1 with oChromIndex=index.
  - On iChromValid, register iChromData into the description register and go to START.
- START:
  - If iDoneProcessing=1 (stale processor state), assert oDoneProcessingFeedback and remain.
  - Else if iReadyToProcess=1, assert oStartProcessing for exactly this cycle and go to RUN.
- RUN:
  - Wait for iDoneProcessing=1.
  - In that cycle, register fitness = zero-extended sum of iErrorSums[0..7] (35 bits, no overflow possible), then go to ACK.
- ACK: assert oDoneProcessingFeedback for one cycle, then go to WRITE.
- WRITE:
  - Pulse oFitnessWrite with oFitnessIndex=index.
  - If fitness < oBestFitness (strict), update the best pair; ties keep the lower index.
  - Go to NEXT.
- NEXT: if index==size-1, go to DONE; otherwise increment index and go to FETCH.
- DONE: oGenerationDone=1; return to IDLE when iStartGeneration is low, so a held start level cannot retrigger.
- The description register changes only in FETCH and is stable from START through ACK.

## Timing
- Reset values:
  - All outputs 0 except oBestFitness=all-ones.
  - oState=IDLE, description register 0.
- Reset mid-generation aborts immediately. The processor is not reset by this block; the START stale-DONE flush recovers it.
- oStartProcessing and oDoneProcessingFeedback are never asserted in the same cycle.
- Each is asserted at most once per individual, apart from the flush.
- Per-individual overhead beyond fetch latency and processor runtime: START(1) + ACK(1) + WRITE(1) + NEXT(1) cycles.
- The fitness sampled is the value of iErrorSums in the first cycle iDoneProcessing is high.
- A size of 255 is clamped to MAX_POPULATION; the index never wraps.

## Structure
- Shared package `ga_sched_pkg`:
  - state enum;
  - FITNESS_WIDTH=35;
  - CHROM_WIDTH default;
  - `error_sum_t` (8x32 array).
- Sub-module `fitness_reducer`: combinational 8-input, 32-bit adder tree producing 35 bits, registered in the parent.

## Test plan
- Size=3, processor model returns error sums {1,0,...}, {0,...}, {2,2,0,...} -> three writes with fitness 1, 0, 4; oBestIndex=1, oBestFitness=0; oGenerationDone=1.
- Size=0 -> DONE within 2 cycles; no oChromRequest, no oStartProcessing, oBestFitness=all-ones.
- Equal fitness 5 for indices 0 and 2 -> oBestIndex=0.
- iDoneProcessing high at the first START -> oDoneProcessingFeedback each cycle until it drops, then exactly one oStartProcessing.
- iReset asserted during RUN at index 1 -> all outputs return to reset values asynchronously; a restart evaluates from index 0.
- Fetch latency of 0 and 7 cycles, and every error sum = 0xFFFFFFFF -> fitness = 0x7_FFFF_FFF8; description held stable during RUN.
